// File: rtl/decode_issue_ctrl.sv
// In-order issue queue between fetch and dispatch; head feeds decode_unit.
// Redirects fetch on a JAL issued from the head and honours pipeline flush.
module decode_issue_ctrl #(
  parameter int CORE         = 0,
  parameter int ADDRESS_BITS = 20,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       fetch_valid,
  input  logic [ADDRESS_BITS-1:0]    fetch_PC,
  input  logic [DATA_WIDTH-1:0]      fetch_instruction,
  output logic                       fetch_ready,
  output logic [ADDRESS_BITS-1:0]    dec_PC,
  output logic [DATA_WIDTH-1:0]      dec_instruction,
  input  logic [6:0]                 opcode,
  input  logic [ADDRESS_BITS-1:0]    JAL_target,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  input  logic                       flush,
  output logic                       redirect_valid,
  output logic [ADDRESS_BITS-1:0]    redirect_PC,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                stall_cycles
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] REDIRECT = 1'b1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CORE < 0) begin : g_bad_param
    $error("decode_issue_ctrl: DEPTH must be a power of 2 >= 2");
  end

  logic [0:0]              state;
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic [ADDRESS_BITS-1:0] pc_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]   ins_mem [DEPTH];

  logic in_run;
  logic empty;
  logic push;
  logic fire;
  logic jal;

  assign in_run = reset & (state == RUN);
  assign empty  = (count == '0);

  assign fetch_ready = in_run & (count < FULL) & ~flush;
  assign issue_valid = in_run & ~empty & ~flush;
  assign redirect_valid = reset & (state == REDIRECT) & ~flush;

  assign push = fetch_valid & fetch_ready;
  assign fire = issue_valid & issue_ready;
  assign jal  = fire & (opcode == OP_JAL);

  // Head is visible combinationally; zeroed when nothing is queued
  assign dec_PC          = empty ? '0 : pc_mem[rd_ptr];
  assign dec_instruction = empty ? '0 : ins_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      redirect_PC <= '0;
    end else if (flush) begin
      state  <= RUN;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (jal) begin
      // Everything behind the JAL is wrong-path
      state       <= REDIRECT;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      redirect_PC <= JAL_target;
    end else begin
      state <= RUN;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (fire) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push & ~fire: count <= count + CW'(1);
        fire & ~push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (push && !jal) begin
      pc_mem[wr_ptr]  <= fetch_PC;
      ins_mem[wr_ptr] <= fetch_instruction;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (issue_valid && !issue_ready &&
                 stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
